// File: rtl/fifo_pkg.sv
// ============================================================================
//  Module  : fifo_pkg
//  Brief   : Shared defaults and buffer-state encoding for the FIFO read path.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

   localparam int c_data_width = 8;
   localparam int c_cnt_width  = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_stream_reader_if.sv
// ============================================================================
//  Module  : fifo_stream_reader_if
//  Brief   : FIFO read port plus output stream bundle for the stream reader.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

interface fifo_stream_reader_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = c_data_width,
   parameter int CNT_WIDTH  = c_cnt_width
);

   logic                  en;
   logic                  empty;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [CNT_WIDTH-1:0]  rd_count;

   modport master (
      input  en, empty, rdata, out_ready,
      output rd_en, out_data, out_valid, rd_count
   );

   modport slave (
      output en, empty, rdata, out_ready,
      input  rd_en, out_data, out_valid, rd_count
   );

endinterface

`default_nettype wire

// File: rtl/fifo_rd_skid.sv
// ============================================================================
//  Module  : fifo_rd_skid
//  Brief   : Two-entry head/tail buffer absorbing the FIFO read latency.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = c_data_width
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_cap_valid,
   input  logic [DATA_WIDTH-1:0] i_cap_data,
   input  logic                  i_pop,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_occ
);

   buf_state_e            r_state;
   buf_state_e            w_state_nxt;
   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_tail;
   logic [DATA_WIDTH-1:0] w_head_nxt;
   logic [DATA_WIDTH-1:0] w_tail_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      case (r_state)
         EMPTY: begin
            if (i_cap_valid) begin
               w_state_nxt = ONE;
               w_head_nxt  = i_cap_data;
            end
         end
         ONE: begin
            case ({i_cap_valid, i_pop})
               2'b11: w_head_nxt = i_cap_data;
               2'b10: begin
                  w_state_nxt = TWO;
                  w_tail_nxt  = i_cap_data;
               end
               2'b01: w_state_nxt = EMPTY;
               default: ;
            endcase
         end
         TWO: begin
            // The reader never pops the FIFO while full, so no capture here.
            if (i_pop) begin
               w_state_nxt = ONE;
               w_head_nxt  = r_tail;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   assign o_valid = (r_state != EMPTY);
   assign o_data  = r_head;
   assign o_occ   = r_state;

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ============================================================================
//  Module  : fifo_stream_reader
//  Brief   : Drains a synchronous FIFO into a valid/ready stream.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = c_data_width,
   parameter int CNT_WIDTH  = c_cnt_width
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_stream_reader_if.master bus
);

   logic                  w_out_valid;
   logic [DATA_WIDTH-1:0] w_out_data;
   logic [1:0]            w_occ;
   logic                  w_pop_out;
   logic [2:0]            w_occ_after;
   logic                  w_rd_en;
   logic                  r_inflight;
   logic [CNT_WIDTH-1:0]  r_rd_count;

   fifo_rd_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .i_cap_valid (r_inflight),
      .i_cap_data  (bus.rdata),
      .i_pop       (w_pop_out),
      .o_valid     (w_out_valid),
      .o_data      (w_out_data),
      .o_occ       (w_occ)
   );

   assign w_pop_out   = w_out_valid & bus.out_ready;
   // Occupancy after the coming edge; a new pop is allowed only if it will fit.
   assign w_occ_after = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop_out};
   assign w_rd_en     = rst & bus.en & ~bus.empty & (w_occ_after < 3'd2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_inflight <= 1'b0;
         r_rd_count <= '0;
      end else begin
         r_inflight <= w_rd_en;
         if (w_rd_en) begin
            r_rd_count <= r_rd_count + CNT_WIDTH'(1);
         end
      end
   end

   assign bus.rd_en     = w_rd_en;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_data;
   assign bus.rd_count  = r_rd_count;

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
//  Module  : tb_fifo_stream_reader
//  Brief   : Directed and random stimulus against a queue-based stream model.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

   localparam int DW = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fifo_stream_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   fifo_stream_reader #(
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] fifo_q  [$];
   logic [DW-1:0] order_q [$];
   logic [DW-1:0] m_buf   [$];
   bit            m_inflight;
   int            m_count;
   logic          dut_rd_s;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      order_q.push_back(w);
      bus.empty = 1'b0;
   endtask

   // Model: buffer holds up to two words, one pop may be in flight.
   task automatic model_step();
      int occ;
      int nxt;
      bit pop;
      bit exp_rd;
      occ    = m_buf.size();
      pop    = (occ > 0) && (bus.out_ready === 1'b1);
      nxt    = occ + int'(m_inflight) - int'(pop);
      exp_rd = (bus.en === 1'b1) && (bus.empty === 1'b0) && (nxt < 2);
      chk("out_valid", 32'(bus.out_valid), 32'(occ > 0));
      if (occ > 0) chk("out_data", 32'(bus.out_data), 32'(m_buf[0]));
      chk("rd_en", 32'(bus.rd_en), 32'(exp_rd));
      chk("rd_count", 32'(bus.rd_count), 32'(m_count));
      if (pop) begin
         if (order_q.size() > 0) chk("order", 32'(bus.out_data), 32'(order_q.pop_front()));
         void'(m_buf.pop_front());
      end
      if (m_inflight) m_buf.push_back(bus.rdata);
      m_inflight = exp_rd;
      m_count    = (m_count + int'(exp_rd)) % (1 << CW);
      dut_rd_s   = bus.rd_en;
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      if (dut_rd_s === 1'b1) begin
         if (fifo_q.size() > 0) bus.rdata = fifo_q.pop_front();
         else                   bus.rdata = 8'hEE;
      end
      bus.empty = (fifo_q.size() == 0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk({tag, "_rst_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_rst_rd_en"}, 32'(bus.rd_en), 32'd0);
      chk({tag, "_rst_count"}, 32'(bus.rd_count), 32'd0);
      chk({tag, "_rst_data"}, 32'(bus.out_data), 32'd0);
      fifo_q.delete();
      order_q.delete();
      m_buf.delete();
      m_inflight = 1'b0;
      m_count    = 0;
      dut_rd_s   = 1'b0;
      bus.rdata  = '0;
      bus.empty  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      bus.en        = 1'b1;
      bus.out_ready = 1'b1;
      while ((fifo_q.size() > 0 || m_buf.size() > 0 || m_inflight) && n < 200) begin
         cycle();
         n++;
      end
      chk({tag, "_drain_bound"}, 32'(n < 200), 32'd1);
      chk({tag, "_all_delivered"}, 32'(order_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b0;
      bus.en        = 1'b0;
      bus.out_ready = 1'b0;
      bus.empty     = 1'b1;
      bus.rdata     = '0;
      m_inflight    = 1'b0;
      m_count       = 0;
      dut_rd_s      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_valid", 32'(bus.out_valid), 32'd0);
      chk("init_rd_en", 32'(bus.rd_en), 32'd0);
      chk("init_count", 32'(bus.rd_count), 32'd0);
      chk("init_data", 32'(bus.out_data), 32'd0);
      rst = 1'b1;

      // Three-word burst at full rate.
      push(8'h11);
      push(8'h22);
      push(8'h33);
      drain("burst");
      chk("burst_count", 32'(bus.rd_count), 32'd3);

      // Backpressure: only two words may leave the FIFO.
      bus.en        = 1'b1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(8'($urandom));
      repeat (6) cycle();
      chk("bp_fifo_left", 32'(fifo_q.size()), 32'd3);
      drain("bp");

      // Permanently empty FIFO.
      bus.en        = 1'b1;
      bus.out_ready = 1'b1;
      repeat (5) cycle();

      // Enable dropped right after one pop.
      for (int i = 0; i < 3; i++) push(8'($urandom));
      cycle();
      bus.en = 1'b0;
      repeat (4) cycle();
      chk("en_off_fifo_left", 32'(fifo_q.size()), 32'd2);
      chk("en_off_undelivered", 32'(order_q.size()), 32'd2);
      drain("en_off");

      // Reset with a full buffer.
      bus.en        = 1'b1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'($urandom));
      repeat (4) cycle();
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      do_reset("mid");
      push(8'hA5);
      push(8'h5A);
      drain("post_rst");

      // Counter wrap with 17 words.
      do_reset("wrap");
      for (int i = 0; i < 17; i++) push(8'(i * 7 + 1));
      drain("wrap");
      chk("wrap_count", 32'(bus.rd_count), 32'd1);

      // Random enable, ready and fill pattern.
      for (int i = 0; i < 300; i++) begin
         bus.en        = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) push(8'($urandom));
         cycle();
      end
      drain("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
